// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU command sequencer.
// Command packing: {use_acc, op, a, b}; results are 8-bit signed.
package alu_pkg;

  localparam int CMD_W = 12;
  localparam int RES_W = 8;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    MUL = 3'd4,
    SHL = 3'd5,
    SHR = 3'd6,
    XOR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic             use_acc;
    alu_op_e          op;
    logic signed [3:0] a;
    logic signed [3:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready streams of the ALU sequencer.
// slave is the sequencer side, master the producer/consumer side.
interface alu_cmd_sequencer_if;
  import alu_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_neg;
  logic             rsp_ovf;

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data,
    input  rsp_zero, rsp_neg, rsp_ovf
  );

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data,
    output rsp_zero, rsp_neg, rsp_ovf
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with wrap-bit pointers for full/empty.
// Read data is the head entry, valid whenever empty is low.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drives registered operands to the external
// ALU and returns the captured result with flags over a stream.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_sequencer_if.slave  bus,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  output logic [2:0]          alu_opcode,
  input  logic [RES_W-1:0]    alu_result,
  output logic                busy
);

  seq_state_e       state;
  seq_state_e       state_nx;
  logic [CMD_W-1:0] head_raw;
  alu_cmd_t         head;
  logic             full;
  logic             empty;
  logic             pop;
  logic             hs;
  logic [3:0]       acc;
  logic [3:0]       acc_src;
  logic [3:0]       a_nx;
  logic [RES_W-1:0] rsp_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .wdata (bus.cmd_data),
    .pop   (pop),
    .rdata (head_raw),
    .full  (full),
    .empty (empty)
  );

  assign head = alu_cmd_t'(head_raw);
  assign hs   = (state == RESP) && bus.rsp_ready;

  // A pop in the handshake cycle must see the result being retired.
  assign acc_src = hs ? rsp_q[3:0] : acc;
  assign a_nx    = head.use_acc ? acc_src : head.a;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: state_nx = RESP;
      RESP: begin
        if (hs) begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = EXEC;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (pop) begin
      alu_a      <= a_nx;
      alu_b      <= head.b;
      alu_opcode <= head.op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q  <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_q  <= alu_result;
      zero_q <= (alu_result == '0);
      neg_q  <= alu_result[RES_W-1];
      ovf_q  <= !((&alu_result[7:3]) || !(|alu_result[7:3]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (hs) begin
      acc <= rsp_q[3:0];
    end
  end

  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_neg   = neg_q;
  assign bus.rsp_ovf   = ovf_q;
  assign busy          = (state != IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, directed scenarios
// and a random stream checked against an in-order accumulator model.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [2:0]       alu_opcode;
  logic [RES_W-1:0] alu_result;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  alu_cmd_t   exp_q[$];
  logic [3:0] macc;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(
    input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int sa;
    int sb;
    int r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd2: r = sa & sb;
      3'd3: r = sa | sb;
      3'd4: r = sa * sb;
      3'd5: r = sa * (1 << b[1:0]);
      3'd6: r = sa >>> b[1:0];
      default: r = sa ^ sb;
    endcase
    return r[7:0];
  endfunction

  always_comb alu_result = alu_fn(alu_a, alu_b, alu_opcode);

  function automatic logic [11:0] mk(
    input logic u, input logic [2:0] op,
    input logic [3:0] a, input logic [3:0] b);
    return {u, op, a, b};
  endfunction

  function automatic logic [2:0] flags_of(input logic [7:0] r);
    int v;
    v = $signed(r);
    return {r == 8'd0, v < 0, (v > 7) || (v < -8)};
  endfunction

  // Commands execute strictly in order, so acc is just the last result.
  function automatic logic [7:0] model_step(input alu_cmd_t c);
    logic [3:0] a_eff;
    logic [7:0] r;
    a_eff = c.use_acc ? macc : c.a;
    r     = alu_fn(a_eff, c.b, c.op);
    macc  = r[3:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_one(input logic [11:0] c,
                        output logic [7:0] d, output logic [2:0] f);
    bit got;
    got = 0;
    d   = 'x;
    f   = 'x;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin
        tick();
        break;
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.rsp_valid) begin
        d   = bus.rsp_data;
        f   = {bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf};
        got = 1;
      end
      tick();
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    macc          = '0;
    tick();
    tick();
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=100",
               {bus.cmd_ready, bus.rsp_valid, busy});
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf} !== 11'd0) begin
      failures++;
      $display("FAIL reset_rsp got=%h exp=0",
               {bus.rsp_data, bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf});
    end
    checks++;
    if ({alu_a, alu_b, alu_opcode} !== 11'd0) begin
      failures++;
      $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_opcode});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = mk(1'b0, ADD, 4'd3, 4'd4);
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, busy} !== 2'b01) begin
      failures++;
      $display("FAIL lat_c1 got=%b exp=01", {bus.rsp_valid, busy});
    end
    tick();
    checks++;
    if ({alu_a, alu_b, alu_opcode, bus.rsp_valid} !== {4'd3, 4'd4, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL lat_load got a=%h b=%h op=%h v=%b exp a=3 b=4 op=0 v=0",
               alu_a, alu_b, alu_opcode, bus.rsp_valid);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf}
        !== {1'b1, 8'h07, 3'b000}) begin
      failures++;
      $display("FAIL lat_rsp got v=%b d=%h f=%b exp v=1 d=07 f=000",
               bus.rsp_valid, bus.rsp_data,
               {bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf});
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL lat_done got=%b exp=00", {bus.rsp_valid, busy});
    end
    macc = 4'h7;
  endtask

  task automatic test_flags();
    logic [7:0] d;
    logic [2:0] f;
    do_one(mk(1'b0, MUL, 4'h8, 4'h8), d, f);
    checks++;
    if ({d, f} !== {8'h40, 3'b001}) begin
      failures++;
      $display("FAIL mul_ovf got d=%h f=%b exp d=40 f=001", d, f);
    end
    do_one(mk(1'b0, SUB, 4'd5, 4'd5), d, f);
    checks++;
    if ({d, f} !== {8'h00, 3'b100}) begin
      failures++;
      $display("FAIL sub_zero got d=%h f=%b exp d=00 f=100", d, f);
    end
    do_one(mk(1'b0, SUB, 4'd2, 4'd5), d, f);
    checks++;
    if ({d, f} !== {8'hFD, 3'b010}) begin
      failures++;
      $display("FAIL sub_neg got d=%h f=%b exp d=fd f=010", d, f);
    end
    macc = 4'hD;
  endtask

  task automatic test_acc_bypass();
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = mk(1'b0, ADD, 4'd3, 4'd4);
    tick();
    bus.cmd_data  = mk(1'b1, ADD, 4'd0, 4'd1);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({alu_a, alu_b} !== {4'd7, 4'd1}) begin
      failures++;
      $display("FAIL bypass_a got a=%h b=%h exp a=7 b=1", alu_a, alu_b);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf}
        !== {1'b1, 8'h08, 3'b001}) begin
      failures++;
      $display("FAIL bypass_rsp got v=%b d=%h f=%b exp v=1 d=08 f=001",
               bus.rsp_valid, bus.rsp_data,
               {bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf});
    end
    tick();
    bus.rsp_ready = 1'b0;
    macc = 4'h8;
  endtask

  task automatic test_backpressure();
    int acc_cnt;
    int got;
    logic [7:0] e;
    alu_cmd_t c;
    acc_cnt = 0;
    got     = 0;
    exp_q.delete();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 12'($urandom);
      if (i == 5) begin
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_full got cmd_ready=%b exp=0", bus.cmd_ready);
        end
      end
      if (bus.cmd_ready) begin
        acc_cnt++;
        exp_q.push_back(alu_cmd_t'(bus.cmd_data));
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (acc_cnt != 5) begin
      failures++;
      $display("FAIL bp_accepted got=%0d exp=5", acc_cnt);
    end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 40 && got < 5; i++) begin
      if (bus.rsp_valid) begin
        c = exp_q.pop_front();
        e = model_step(c);
        got++;
        checks++;
        if ({bus.rsp_data, bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf}
            !== {e, flags_of(e)}) begin
          failures++;
          $display("FAIL bp_rsp%0d got d=%h f=%b exp d=%h f=%b", got,
                   bus.rsp_data, {bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf},
                   e, flags_of(e));
        end
      end
      tick();
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if ({got, bus.cmd_ready, busy} !== {32'd5, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL bp_drain got n=%0d rdy=%b busy=%b exp n=5 rdy=1 busy=0",
               got, bus.cmd_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [2:0] f;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_data = mk(1'b0, ADD, 4'(i + 1), 4'd1);
      tick();
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b11) begin
      failures++;
      $display("FAIL rm_pre got=%b exp=11", {bus.rsp_valid, bus.cmd_ready});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, busy, bus.cmd_ready, alu_a} !== {3'b001, 4'd0}) begin
      failures++;
      $display("FAIL rm_async got v=%b busy=%b rdy=%b a=%h exp 0 0 1 0",
               bus.rsp_valid, busy, bus.cmd_ready, alu_a);
    end
    tick();
    rst_n = 1'b1;
    macc  = '0;
    tick();
    tick();
    tick();
    checks++;
    if ({bus.rsp_valid, busy, bus.cmd_ready} !== 3'b001) begin
      failures++;
      $display("FAIL rm_stale got v=%b busy=%b rdy=%b exp 0 0 1",
               bus.rsp_valid, busy, bus.cmd_ready);
    end
    do_one(mk(1'b1, ADD, 4'd5, 4'd2), d, f);
    checks++;
    if ({d, f} !== {8'h02, 3'b000}) begin
      failures++;
      $display("FAIL rm_acc got d=%h f=%b exp d=02 f=000", d, f);
    end
    macc = 4'h2;
  endtask

  task automatic test_random();
    logic [7:0] e;
    logic [7:0] pd;
    logic [2:0] pf;
    logic       stall;
    int         nrsp;
    alu_cmd_t   c;
    stall = 1'b0;
    nrsp  = 0;
    pd    = '0;
    pf    = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 1200; cyc++) begin
      bus.cmd_valid = ($urandom_range(0, 9) < 6);
      bus.cmd_data  = 12'($urandom);
      bus.rsp_ready = (cyc >= 1000) || ($urandom_range(0, 1) == 1);
      if (cyc >= 1000) bus.cmd_valid = 1'b0;
      if (stall) begin
        checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_neg,
             bus.rsp_ovf} !== {1'b1, pd, pf}) begin
          failures++;
          $display("FAIL rnd_stable got v=%b d=%h f=%b exp v=1 d=%h f=%b",
                   bus.rsp_valid, bus.rsp_data,
                   {bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf}, pd, pf);
        end
      end
      if (bus.cmd_valid && bus.cmd_ready)
        exp_q.push_back(alu_cmd_t'(bus.cmd_data));
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra got unexpected rsp d=%h exp none",
                   bus.rsp_data);
        end else begin
          c = exp_q.pop_front();
          e = model_step(c);
          nrsp++;
          if ({bus.rsp_data, bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf}
              !== {e, flags_of(e)}) begin
            failures++;
            $display("FAIL rnd_rsp%0d got d=%h f=%b exp d=%h f=%b", nrsp,
                     bus.rsp_data, {bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf},
                     e, flags_of(e));
          end
        end
      end
      stall = bus.rsp_valid && !bus.rsp_ready;
      pd    = bus.rsp_data;
      pf    = {bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf};
      tick();
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || nrsp < 50) begin
      failures++;
      $display("FAIL rnd_drain got left=%0d busy=%b n=%0d exp left=0 busy=0 n>=50",
               exp_q.size(), busy, nrsp);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_flags();
    test_acc_bypass();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side front end for the team's combinational 4-bit signed ALU. It accepts packed ALU commands over a valid/ready stream, buffers them in a small FIFO, and drives registered operands and an opcode to the ALU. It captures the 8-bit ALU result with status flags and returns it over a valid/ready response stream. An accumulator mode chains results into the next command's `a` operand.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries; must be a power of 2, at least 2.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_data` in 12: [11] `use_acc`, [10:8] opcode, [7:4] `a` (signed), [3:0] `b` (signed).
- `alu_a` out 4: registered operand to ALU.
- `alu_b` out 4: registered operand to ALU.
- `alu_opcode` out 3: registered opcode to ALU.
- `alu_result` in 8: combinational signed ALU result.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: downstream accepts.
- `rsp_data` out 8: captured result.
- `rsp_zero` out 1: result == 0.
- `rsp_neg` out 1: result[7].
- `rsp_ovf` out 1: result outside −8..7, i.e. result[7:3] not all equal.
- `busy` out 1: state != IDLE or FIFO non-empty.

## Operation
- Push on `cmd_valid && cmd_ready`.
- `cmd_ready = !full`, combinational from FIFO count. There is no pass-through when full, even if a pop occurs in the same cycle.
- A pushed entry becomes poppable the following cycle. There is no empty-FIFO bypass.
- FSM states are IDLE, EXEC, RESP.
  - IDLE: if FIFO non-empty, pop, load `alu_*`, go to EXEC. Otherwise stay.
  - EXEC: capture `alu_result` into `rsp_data` and flags, go to RESP.
  - RESP: `rsp_valid`=1, and response outputs stay stable until handshake. On `rsp_valid && rsp_ready`, update `acc <= rsp_data[3:0]`. Then, if FIFO non-empty, pop, load `alu_*` and go to EXEC in the same cycle. Otherwise go to IDLE.
- Operand load:
  - `alu_b` and `alu_opcode` come from the popped entry.
  - `alu_a` = `use_acc` ? acc : entry `a`.
  - When the pop coincides with the response handshake, `use_acc` takes `rsp_data[3:0]`, bypassing the stale acc.
- acc is 4-bit and truncates, with no saturation. Overflow is reported only through `rsp_ovf`.
- `alu_*` hold their last value outside load cycles.

## Timing
- Reset values:
  - `cmd_ready`=1, `rsp_valid`=0, `busy`=0.
  - `rsp_data`, `rsp_zero`, `rsp_neg`, `rsp_ovf` = 0.
  - `alu_a`, `alu_b`, `alu_opcode` = 0; acc=0.
  - FIFO empty; state IDLE.
- Latency with FIFO empty and IDLE, push at cycle 0:
  - pop and load at cycle 1;
  - capture at cycle 2;
  - `rsp_valid` high at cycle 3.
- Throughput is 1 response per 2 cycles with `rsp_ready` held high.
- `rsp_ready` low stalls in RESP. FIFO keeps accepting until full.
- Reset asserted mid-operation: all state clears immediately and asynchronously. `rsp_valid` drops, FIFO contents are discarded, acc=0.
- Opcode values 0–7 are all legal. The block does not interpret them.

## Structure
- Shared package `alu_pkg` holds:
  - `alu_op_e` (ADD, SUB, AND, OR, MUL, SHL, SHR, XOR = 0..7);
  - packed struct `alu_cmd_t` {`use_acc`, op, a, b};
  - `seq_state_e`;
  - `CMD_W` = 12, `RES_W` = 8.
- One sub-module: `alu_cmd_fifo`, a parameterised synchronous FIFO with full/empty and registered pointers.
- The FSM, operand mux and response register live in the top.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Push ADD a=3 b=4 → `alu_a`=3, `alu_b`=4, opcode=0 at cycle 2; `rsp_data`=0x07 at cycle 3; zero=0, neg=0, ovf=0.
- Push MUL a=−8 b=−8 → `rsp_data`=0x40, `rsp_ovf`=1. Push SUB a=5 b=5 → `rsp_data`=0x00, `rsp_zero`=1.
- Push ADD 3,4, then `use_acc` ADD b=1, with `rsp_ready`=1 → second command drives `alu_a`=7 via the bypass; `rsp_data`=0x08, ovf=1.
- Hold `rsp_ready`=0 and offer 6 commands back-to-back (`FIFO_DEPTH`=4) → 5 accepted (1 popped + 4 stored), `cmd_ready`=0 on the 6th. Release `rsp_ready` → 5 responses in order, then `cmd_ready`=1 and `busy`→0.
- Drive `rst_n` low while in RESP with FIFO holding 2 entries → `rsp_valid`=0 immediately; after release, `cmd_ready`=1, `busy`=0, no stale responses; a `use_acc` ADD b=2 returns 0x02.
- Random opcode/operand stream with random `rsp_ready` → responses match the scoreboard model including acc chaining; `rsp_*` stable while valid and not ready.
